// File: rtl/gpzda_field_parser.sv
// rtl/gpzda_field_parser.sv - GPZDA time/date field decoder; optional checksum check enabled by GPZDA_CHECKSUM_EN
module gpzda_field_parser #(
   parameter logic [7:0]  SEED     = 8'h48,
   parameter int unsigned FRAC_MAX = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        load,
   input  logic [7:0]  data,
   output logic [4:0]  hour,
   output logic [5:0]  minute,
   output logic [5:0]  second,
   output logic [4:0]  day,
   output logic [3:0]  month,
   output logic [13:0] year,
   output logic        valid,
   output logic        error
);

   typedef enum logic [3:0] {
      IDLE, SEP0, TIME, FRAC, DAY, MONTH, YEAR, ZONE
`ifdef GPZDA_CHECKSUM_EN
      , CSUM_HI, CSUM_LO
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [13:0] acc, acc_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        zone_sep, zone_sep_nxt;
   logic [6:0]  p_hour, p_hour_nxt;
   logic [6:0]  p_minute, p_minute_nxt;
   logic [6:0]  p_second, p_second_nxt;
   logic [6:0]  p_day, p_day_nxt;
   logic [6:0]  p_month, p_month_nxt;
   logic [13:0] p_year, p_year_nxt;
   logic        valid_nxt, error_nxt, commit;

   logic        is_digit, is_term, range_ok;
   logic [3:0]  dig;
   logic [13:0] val;

`ifdef GPZDA_CHECKSUM_EN
   logic [7:0]  csum, csum_nxt;
   logic        hex_ok;
   logic [3:0]  hex_nib;
`endif

   assign is_digit = (data >= 8'h30) && (data <= 8'h39);
   // For an ASCII digit the low nibble equals data - 8'h30.
   assign dig      = data[3:0];
   // At most four digits ever accumulate, so 9999 fits without overflow.
   assign val      = (acc * 14'd10) + {10'd0, dig};
   assign range_ok = (p_hour <= 7'd23) && (p_minute <= 7'd59) && (p_second <= 7'd60) &&
                     (p_day >= 7'd1) && (p_day <= 7'd31) &&
                     (p_month >= 7'd1) && (p_month <= 7'd12);

`ifdef GPZDA_CHECKSUM_EN
   assign is_term = (data == 8'h2A);

   // Uppercase hex digit decode for the two checksum characters.
   always_comb begin
      hex_ok  = 1'b1;
      hex_nib = data[3:0];
      if (is_digit) begin
         hex_nib = data[3:0];
      end else if ((data >= 8'h41) && (data <= 8'h46)) begin
         hex_nib = data[3:0] + 4'd9;
      end else begin
         hex_ok = 1'b0;
      end
   end
`else
   assign is_term = (data == 8'h2A) || (data == 8'h0D);
`endif

   // Next-state, datapath and pulse decode for one consumed byte.
   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      cnt_nxt      = cnt;
      zone_sep_nxt = zone_sep;
      p_hour_nxt   = p_hour;
      p_minute_nxt = p_minute;
      p_second_nxt = p_second;
      p_day_nxt    = p_day;
      p_month_nxt  = p_month;
      p_year_nxt   = p_year;
      valid_nxt    = 1'b0;
      error_nxt    = 1'b0;
      commit       = 1'b0;
`ifdef GPZDA_CHECKSUM_EN
      csum_nxt     = csum;
`endif
      if (start) begin
         state_nxt    = SEP0;
         acc_nxt      = '0;
         cnt_nxt      = '0;
         zone_sep_nxt = 1'b0;
`ifdef GPZDA_CHECKSUM_EN
         csum_nxt     = SEED;
`endif
      end else if (load) begin
`ifdef GPZDA_CHECKSUM_EN
         if ((state != IDLE) && (state != CSUM_HI) && (state != CSUM_LO) && (data != 8'h2A))
            csum_nxt = csum ^ data;
`endif
         case (state)
            SEP0: begin
               if (data == 8'h2C) state_nxt = TIME;
               else error_nxt = 1'b1;
            end
            TIME: begin
               if (is_digit) begin
                  if (cnt == 4'd6) begin
                     error_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + 4'd1;
                     // Time digits pair up as hh mm ss; each completed pair is latched.
                     if (cnt[0]) begin
                        acc_nxt = '0;
                        case (cnt)
                           4'd1:    p_hour_nxt   = val[6:0];
                           4'd3:    p_minute_nxt = val[6:0];
                           default: p_second_nxt = val[6:0];
                        endcase
                     end else begin
                        acc_nxt = val;
                     end
                  end
               end else if ((data == 8'h2E) && (cnt == 4'd6)) begin
                  state_nxt = FRAC;
                  cnt_nxt   = '0;
               end else if ((data == 8'h2C) && (cnt == 4'd6)) begin
                  state_nxt = DAY;
                  cnt_nxt   = '0;
                  acc_nxt   = '0;
               end else begin
                  error_nxt = 1'b1;
               end
            end
            FRAC: begin
               if (is_digit && ({28'd0, cnt} < FRAC_MAX)) begin
                  cnt_nxt = cnt + 4'd1;
               end else if (data == 8'h2C) begin
                  state_nxt = DAY;
                  cnt_nxt   = '0;
                  acc_nxt   = '0;
               end else begin
                  error_nxt = 1'b1;
               end
            end
            DAY, MONTH, YEAR: begin
               if (is_digit && (cnt != ((state == YEAR) ? 4'd4 : 4'd2))) begin
                  acc_nxt = val;
                  cnt_nxt = cnt + 4'd1;
               end else if ((data == 8'h2C) && (cnt == ((state == YEAR) ? 4'd4 : 4'd2))) begin
                  acc_nxt = '0;
                  cnt_nxt = '0;
                  if (state == DAY) begin
                     p_day_nxt = acc[6:0];
                     state_nxt = MONTH;
                  end else if (state == MONTH) begin
                     p_month_nxt = acc[6:0];
                     state_nxt   = YEAR;
                  end else begin
                     p_year_nxt   = acc;
                     zone_sep_nxt = 1'b0;
                     state_nxt    = ZONE;
                  end
               end else begin
                  error_nxt = 1'b1;
               end
            end
            ZONE: begin
               if (is_digit && (cnt != 4'd2)) begin
                  cnt_nxt = cnt + 4'd1;
               end else if ((data == 8'h2C) && !zone_sep) begin
                  zone_sep_nxt = 1'b1;
                  cnt_nxt      = '0;
               end else if (is_term && zone_sep && range_ok) begin
`ifdef GPZDA_CHECKSUM_EN
                  state_nxt = CSUM_HI;
`else
                  commit = 1'b1;
`endif
               end else begin
                  error_nxt = 1'b1;
               end
            end
`ifdef GPZDA_CHECKSUM_EN
            CSUM_HI: begin
               if (hex_ok) begin
                  acc_nxt   = {10'd0, hex_nib};
                  state_nxt = CSUM_LO;
               end else begin
                  error_nxt = 1'b1;
               end
            end
            CSUM_LO: begin
               if (hex_ok && ({acc[3:0], hex_nib} == csum)) commit = 1'b1;
               else error_nxt = 1'b1;
            end
`endif
            default: ;
         endcase
         if (commit) valid_nxt = 1'b1;
         if (commit || error_nxt) state_nxt = IDLE;
      end
   end

   // Parser state, pending fields and registered result pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         zone_sep <= 1'b0;
         p_hour   <= '0;
         p_minute <= '0;
         p_second <= '0;
         p_day    <= '0;
         p_month  <= '0;
         p_year   <= '0;
         valid    <= 1'b0;
         error    <= 1'b0;
`ifdef GPZDA_CHECKSUM_EN
         csum     <= SEED;
`endif
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         cnt      <= cnt_nxt;
         zone_sep <= zone_sep_nxt;
         p_hour   <= p_hour_nxt;
         p_minute <= p_minute_nxt;
         p_second <= p_second_nxt;
         p_day    <= p_day_nxt;
         p_month  <= p_month_nxt;
         p_year   <= p_year_nxt;
         valid    <= valid_nxt;
         error    <= error_nxt;
`ifdef GPZDA_CHECKSUM_EN
         csum     <= csum_nxt;
`endif
      end
   end

   // Visible fields change only when a whole sentence is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hour   <= '0;
         minute <= '0;
         second <= '0;
         day    <= '0;
         month  <= '0;
         year   <= '0;
      end else if (commit) begin
         hour   <= p_hour[4:0];
         minute <= p_minute[5:0];
         second <= p_second[5:0];
         day    <= p_day[4:0];
         month  <= p_month[3:0];
         year   <= p_year;
      end
   end

endmodule
